// File: rtl/cmp_pkg.sv
// Shared types and constants for the sequenced magnitude comparator.
package cmp_pkg;

  localparam int unsigned PAIR_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } cmp_state_t;

  // Pair index width: $clog2(S/2), never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned s);
    return (s / 2 > 1) ? $clog2(s / 2) : 1;
  endfunction

endpackage

// File: rtl/pair_cmp_slice.sv
// Combinational 2-bit magnitude compare slice with cascade inputs.
module pair_cmp_slice
  import cmp_pkg::*;
(
  input  logic [PAIR_W-1:0] a_i,
  input  logic [PAIR_W-1:0] b_i,
  input  logic              eq_i,
  input  logic              gt_i,
  output logic              eq_o,
  output logic              gt_o
);

  // A more-significant decision (eq_i == 0) overrides this pair.
  always_comb begin
    eq_o = eq_i;
    gt_o = gt_i;
    if (eq_i) begin
      eq_o = (a_i == b_i);
      gt_o = (a_i > b_i);
    end
  end

endmodule

// File: rtl/serial_cmp_ctrl.sv
// Multi-cycle magnitude comparator: one 2-bit slice scans operand pairs MSB to LSB.
// Define SERIAL_CMP_EARLY_EXIT_EN to finish as soon as the result is decided.
module serial_cmp_ctrl
  import cmp_pkg::*;
#(
  parameter int unsigned S = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [S-1:0] a,
  input  logic [S-1:0] b,
  input  logic         eq_in,
  input  logic         gt_in,
  output logic         busy,
  output logic         done,
  output logic         eq,
  output logic         gt
);

  localparam int unsigned IdxW = idx_width(S);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(S / 2 - 1);

  cmp_state_t state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [S-1:0] a_q, a_d;
  logic [S-1:0] b_q, b_d;
  logic acc_eq_q, acc_eq_d;
  logic acc_gt_q, acc_gt_d;
  logic eq_q, eq_d;
  logic gt_q, gt_d;

  logic [S-1:0] a_sh, b_sh;
  logic [PAIR_W-1:0] a_pair, b_pair;
  logic new_eq, new_gt;
  logic last_pair;

  assign a_sh   = a_q >> {idx_q, 1'b0};
  assign b_sh   = b_q >> {idx_q, 1'b0};
  assign a_pair = a_sh[PAIR_W-1:0];
  assign b_pair = b_sh[PAIR_W-1:0];

  pair_cmp_slice u_slice (
    .a_i  (a_pair),
    .b_i  (b_pair),
    .eq_i (acc_eq_q),
    .gt_i (acc_gt_q),
    .eq_o (new_eq),
    .gt_o (new_gt)
  );

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  // Once a pair differs the remaining pairs only pass the accumulator through.
  assign last_pair = (idx_q == '0) || !new_eq;
`else
  assign last_pair = (idx_q == '0);
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_eq_d = acc_eq_q;
    acc_gt_d = acc_gt_q;
    eq_d     = eq_q;
    gt_d     = gt_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          acc_eq_d = eq_in;
          acc_gt_d = gt_in;
          idx_d    = IdxLast;
          state_d  = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_eq_d = new_eq;
        acc_gt_d = new_gt;
        if (last_pair) begin
          eq_d    = new_eq;
          gt_d    = new_gt;
          state_d = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_eq_q <= 1'b0;
      acc_gt_q <= 1'b0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_eq_q <= acc_eq_d;
      acc_gt_q <= acc_gt_d;
      eq_q     <= eq_d;
      gt_q     <= gt_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign eq   = eq_q;
  assign gt   = gt_q;

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Directed self-checking bench for serial_cmp_ctrl (S=8), both latency builds.
module tb_serial_cmp_ctrl;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EarlyExit = 1'b1;
`else
  localparam bit EarlyExit = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       eq_in, gt_in;
  logic       busy, done, eq, gt;

  int n_checks = 0;
  int n_fails  = 0;
  int lat, bcnt;

  serial_cmp_ctrl #(.S(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .eq_in (eq_in),
    .gt_in (gt_in),
    .busy  (busy),
    .done  (done),
    .eq    (eq),
    .gt    (gt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a start for one edge; returns #1 into cycle 1.
  task automatic launch(input logic [7:0] av, input logic [7:0] bv, input logic ei,
                        input logic gi);
    @(negedge clk);
    a     = av;
    b     = bv;
    eq_in = ei;
    gt_in = gi;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts cycles until done; optionally pulses start mid-compare with other operands.
  task automatic wait_done(input bit pulse, output int l, output int bc);
    l  = 0;
    bc = 0;
    for (int n = 1; n <= 20; n++) begin
      if (done) begin
        l = n;
        break;
      end
      if (busy) bc++;
      if (pulse && n == 2) begin
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'h00;
      end
      if (pulse && n == 3) start = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_cmp(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic ei, input logic gi, input logic xeq, input logic xgt,
                         input int xlat);
    int l, bc;
    launch(av, bv, ei, gi);
    wait_done(1'b0, l, bc);
    chk({tag, "_lat"}, l, xlat);
    chk({tag, "_busy_cycles"}, bc, xlat - 1);
    chk({tag, "_busy_at_done"}, busy, 1'b0);
    chk({tag, "_eq"}, eq, xeq);
    chk({tag, "_gt"}, gt, xgt);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_eq_hold"}, eq, xeq);
    chk({tag, "_gt_hold"}, gt, xgt);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    eq_in = 1'b1;
    gt_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_eq", eq, 1'b0);
    chk("reset_gt", gt, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    run_cmp("equal_a5", 8'hA5, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 5);
    run_cmp("msb_gt", 8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1, EarlyExit ? 2 : 5);
    run_cmp("lsb_lt", 8'h12, 8'h13, 1'b1, 1'b0, 1'b0, 1'b0, 5);
    run_cmp("seed_gt", 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, EarlyExit ? 2 : 5);

    // Back-to-back: start pulses while busy are ignored, start held in DONE is accepted.
    launch(8'hA5, 8'hA5, 1'b1, 1'b0);
    wait_done(1'b1, lat, bcnt);
    chk("b2b_first_lat", lat, 5);
    chk("b2b_first_eq", eq, 1'b1);
    chk("b2b_first_gt", gt, 1'b0);
    a     = 8'h01;
    b     = 8'h00;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_accept_busy", busy, 1'b1);
    wait_done(1'b0, lat, bcnt);
    chk("b2b_second_lat", lat, 5);
    chk("b2b_second_eq", eq, 1'b0);
    chk("b2b_second_gt", gt, 1'b1);

    // Reset in RUN cycle 2 clears everything asynchronously.
    launch(8'hA5, 8'hA5, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("midrun_busy_before", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrun_rst_busy", busy, 1'b0);
    chk("midrun_rst_done", done, 1'b0);
    chk("midrun_rst_eq", eq, 1'b0);
    chk("midrun_rst_gt", gt, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_idle", busy, 1'b0);
    run_cmp("post_rst", 8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1, EarlyExit ? 2 : 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
